// File: rtl/sram_controller.sv
`timescale 1ns/1ps
// sram_controller
// Services each 32-bit data-memory read or write from the MEM stage as two
// 16-bit accesses (low half, then high half) to an external asynchronous SRAM.
// While a request is in flight, ready is low so the pipeline freezes.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   wr_en/rd_en  level requests, held until ready; both high means write
//   address      byte address; word = (address - MEM_BASE) >> 2
//   write_data   store data
//   read_data    registered load result, held until the next read completes
//   ready        1 when no request is pending or the request completes now
//   sram_addr    half-word address {word, half}
//   sram_dq_out  write data toward the SRAM
//   sram_dq_in   read data from the SRAM
//   sram_dq_oe   1 while the controller drives the DQ bus
//   sram_we_n    active-low write strobe
//   sram_oe_n    active-low output enable
module sram_controller #(
  parameter int MEM_BASE      = 1024,
  parameter int ACCESS_CYCLES = 2,
  parameter int SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int CW = $clog2(ACCESS_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state, next_state;
  logic [CW-1:0]      count, next_count;
  logic               op_write, next_write;
  logic [SRAM_AW-2:0] word, next_word;
  logic [31:0]        data, next_data;
  logic [31:0]        offset;
  logic               last_cycle;
  logic               next_active;

  // Word index relative to MEM_BASE; taking bits [SRAM_AW:2] both drops the
  // byte offset and wraps the word modulo the SRAM size.
  assign offset     = address - 32'(MEM_BASE);
  assign last_cycle = (count == LAST);

  always_comb begin
    next_state = state;
    next_count = count;
    next_write = op_write;
    next_word  = word;
    next_data  = data;
    case (state)
      IDLE: begin
        if (rd_en || wr_en) begin
          next_state = LOW;
          next_count = '0;
          next_write = wr_en;
          next_word  = offset[SRAM_AW:2];
          next_data  = write_data;
        end
      end
      LOW: begin
        if (last_cycle) begin
          next_state = HIGH;
          next_count = '0;
        end else begin
          next_count = count + CW'(1);
        end
      end
      HIGH: begin
        if (last_cycle) begin
          next_state = DONE;
          next_count = '0;
        end else begin
          next_count = count + CW'(1);
        end
      end
      default: begin
        // DONE returns to IDLE regardless of the request lines, so the
        // still-held request of the finished instruction is not restarted.
        next_state = IDLE;
        next_count = '0;
      end
    endcase
  end

  assign next_active = (next_state == LOW) || (next_state == HIGH);
  assign ready = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);

  // SRAM pins are registered from the next-state values so they line up with
  // the state/count of the cycle they belong to and stay glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= '0;
      op_write    <= 1'b0;
      word        <= '0;
      data        <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      state    <= next_state;
      count    <= next_count;
      op_write <= next_write;
      word     <= next_word;
      data     <= next_data;

      // The SRAM output has had the whole phase to settle by its last cycle.
      if (!op_write && last_cycle) begin
        if (state == LOW)
          read_data[15:0] <= sram_dq_in;
        else if (state == HIGH)
          read_data[31:16] <= sram_dq_in;
      end

      if (next_state == LOW)
        sram_addr <= {next_word, 1'b0};
      else if (next_state == HIGH)
        sram_addr <= {next_word, 1'b1};

      if (next_active && next_write)
        sram_dq_out <= (next_state == LOW) ? next_data[15:0] : next_data[31:16];

      // Cycle 0 of each phase is address setup; the strobe follows.
      sram_dq_oe <= next_active && next_write;
      sram_we_n  <= !(next_active && next_write && (next_count != '0));
      sram_oe_n  <= !(next_active && !next_write);
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
`timescale 1ns/1ps
// tb_sram_controller
// Self-checking bench for sram_controller. An SRAM model answers the DUT, a
// transaction-level reference model predicts every output on every cycle,
// and directed requests pin the model with hand-computed values. A second
// instance with three clocks per access checks the stretched latency.
module tb_sram_controller;

  localparam int AC   = 2;
  localparam int BASE = 1024;
  localparam int AW   = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [AW-1:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  logic        wr3 = 1'b0, rd3 = 1'b0;
  logic [31:0] address3 = 32'd1024, write_data3 = 32'h12345678;
  logic [31:0] read_data3;
  logic        ready3;
  logic [AW-1:0] sram_addr3;
  logic [15:0] sram_dq_out3;
  logic [15:0] sram_dq_in3 = 16'h0;
  logic        sram_dq_oe3, sram_we_n3, sram_oe_n3;

  int total = 0;
  int bad   = 0;

  logic [15:0] env_mem [0:(1<<AW)-1];
  logic [15:0] shadow  [0:(1<<AW)-1];

  // Model state
  bit          m_busy = 0;
  int          m_k = 0;
  bit          m_wr = 0;
  int unsigned m_word = 0;
  logic [31:0] m_data = '0;
  logic [31:0] m_rd = '0;
  logic [AW-1:0] m_addr = '0;
  logic [15:0] m_dq = '0;

  // Observations gathered by apply_stimulus
  int          lat;
  int          oe_low;
  logic [31:0] rd_at_ready;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_dq[$];

  sram_controller #(.MEM_BASE(BASE), .ACCESS_CYCLES(AC), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  sram_controller #(.MEM_BASE(BASE), .ACCESS_CYCLES(3), .SRAM_AW(AW)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr3), .rd_en(rd3), .address(address3),
    .write_data(write_data3), .read_data(read_data3), .ready(ready3),
    .sram_addr(sram_addr3), .sram_dq_out(sram_dq_out3), .sram_dq_in(sram_dq_in3),
    .sram_dq_oe(sram_dq_oe3), .sram_we_n(sram_we_n3), .sram_oe_n(sram_oe_n3)
  );

  assign sram_dq_in = env_mem[sram_addr];

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM environment plus reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    int phase;
    int sub;
    int unsigned a;
    logic [31:0] off;
    if (sram_we_n === 1'b0)
      env_mem[sram_addr] = sram_dq_out;

    if (!rst) begin
      check_output("rst_ready", 32'(ready), 32'(!(rd_en || wr_en)));
      check_output("rst_read_data", read_data, 32'h0);
      check_output("rst_addr", 32'(sram_addr), 32'h0);
      check_output("rst_dq_out", 32'(sram_dq_out), 32'h0);
      check_output("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
      check_output("rst_we_n", 32'(sram_we_n), 32'h1);
      check_output("rst_oe_n", 32'(sram_oe_n), 32'h1);
      m_busy = 0;
      m_rd   = '0;
      m_addr = '0;
      m_dq   = '0;
    end else if (!m_busy) begin
      check_output("idle_ready", 32'(ready), 32'(!(rd_en || wr_en)));
      check_output("idle_we_n", 32'(sram_we_n), 32'h1);
      check_output("idle_oe_n", 32'(sram_oe_n), 32'h1);
      check_output("idle_dq_oe", 32'(sram_dq_oe), 32'h0);
      check_output("idle_addr", 32'(sram_addr), 32'(m_addr));
      check_output("idle_dq_out", 32'(sram_dq_out), 32'(m_dq));
      check_output("idle_read_data", read_data, m_rd);
      if (rd_en || wr_en) begin
        m_busy = 1;
        m_k    = 1;
        m_wr   = wr_en;
        off    = address - 32'(BASE);
        m_word = (off >> 2) % (1 << (AW - 1));
        m_data = write_data;
      end
    end else if (m_k <= 2 * AC) begin
      phase  = (m_k - 1) / AC;
      sub    = (m_k - 1) % AC;
      a      = m_word * 2 + phase;
      m_addr = AW'(a);
      if (m_wr)
        m_dq = (phase == 1) ? m_data[31:16] : m_data[15:0];
      check_output("busy_ready", 32'(ready), 32'h0);
      check_output("busy_addr", 32'(sram_addr), 32'(m_addr));
      check_output("busy_dq_oe", 32'(sram_dq_oe), 32'(m_wr));
      check_output("busy_we_n", 32'(sram_we_n), 32'(!(m_wr && sub != 0)));
      check_output("busy_oe_n", 32'(sram_oe_n), 32'(m_wr));
      check_output("busy_dq_out", 32'(sram_dq_out), 32'(m_dq));
      check_output("busy_read_data", read_data, m_rd);
      if (m_wr && sub != 0)
        shadow[a] = m_dq;
      if (!m_wr && sub == AC - 1) begin
        if (phase == 1) m_rd[31:16] = shadow[a];
        else            m_rd[15:0]  = shadow[a];
      end
      m_k++;
    end else begin
      check_output("done_ready", 32'(ready), 32'h1);
      check_output("done_we_n", 32'(sram_we_n), 32'h1);
      check_output("done_oe_n", 32'(sram_oe_n), 32'h1);
      check_output("done_dq_oe", 32'(sram_dq_oe), 32'h0);
      check_output("done_addr", 32'(sram_addr), 32'(m_addr));
      check_output("done_dq_out", 32'(sram_dq_out), 32'(m_dq));
      check_output("done_read_data", read_data, m_rd);
      m_busy = 0;
    end
  end

  // Called just after a rising edge with the DUT idle. Holds the request
  // until ready, records strobes, then drops the request after the edge.
  task automatic apply_stimulus(input bit wr, input bit rd, input logic [31:0] addr,
                                input logic [31:0] wdata);
    bit seen;
    wr_en = wr;
    rd_en = rd;
    address = addr;
    write_data = wdata;
    lat = 0;
    oe_low = 0;
    seen = 0;
    wq_addr.delete();
    wq_dq.delete();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sram_we_n === 1'b0) begin
        wq_addr.push_back(32'(sram_addr));
        wq_dq.push_back(32'(sram_dq_out));
      end
      if (sram_oe_n === 1'b0) oe_low++;
      if (ready === 1'b1) begin
        rd_at_ready = read_data;
        seen = 1;
        break;
      end
      lat++;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL req_timeout: got no ready expected ready within 50 cycles");
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    int v;
    int gap;
    int op;
    int lat3;
    int we3;
    logic [31:0] a;
    for (int i = 0; i < (1 << AW); i++) begin
      v = (i * 40503) ^ 32'h5a5a;
      env_mem[i] = 16'(v);
      shadow[i]  = 16'(v);
    end

    // Reset held, then released just after an edge.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_output("post_reset_ready", 32'(ready), 32'h1);
    check_output("post_reset_read_data", read_data, 32'h0);
    @(posedge clk);
    #1;

    $display("[TB] write 0xDEADBEEF to 1028");
    apply_stimulus(1, 0, 32'd1028, 32'hDEADBEEF);
    check_output("wr_latency", 32'(lat), 32'd5);
    check_output("wr_pulses", 32'(wq_addr.size()), 32'd2);
    if (wq_addr.size() == 2) begin
      check_output("wr_low_addr", wq_addr[0], 32'd2);
      check_output("wr_low_dq", wq_dq[0], 32'hBEEF);
      check_output("wr_high_addr", wq_addr[1], 32'd3);
      check_output("wr_high_dq", wq_dq[1], 32'hDEAD);
    end

    $display("[TB] read back 1028");
    apply_stimulus(0, 1, 32'd1028, 32'h0);
    check_output("rd_latency", 32'(lat), 32'd5);
    check_output("rd_data_at_ready", rd_at_ready, 32'hDEADBEEF);
    check_output("rd_oe_cycles", 32'(oe_low), 32'd4);

    $display("[TB] back-to-back write then read of 1024");
    apply_stimulus(1, 0, 32'd1024, 32'h13579BDF);
    apply_stimulus(0, 1, 32'd1024, 32'h0);
    check_output("b2b_read", rd_at_ready, 32'h13579BDF);
    check_output("b2b_no_extra_write", 32'(wq_addr.size()), 32'd0);

    $display("[TB] reset during high phase of a write");
    wr_en = 1'b1;
    address = 32'd1032;
    write_data = 32'hCAFEF00D;
    repeat (4) @(posedge clk);
    #1;
    check_output("abort_in_strobe", 32'(sram_we_n), 32'h0);
    rst = 1'b0;
    #1;
    check_output("abort_we_n", 32'(sram_we_n), 32'h1);
    check_output("abort_dq_oe", 32'(sram_dq_oe), 32'h0);
    wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(0, 1, 32'd1032, 32'h0);
    check_output("abort_then_read_latency", 32'(lat), 32'd5);
    check_output("abort_low_half_kept", 32'(rd_at_ready[15:0]), 32'hF00D);

    $display("[TB] simultaneous rd_en and wr_en");
    apply_stimulus(1, 1, 32'd1040, 32'hA5A55A5A);
    check_output("both_is_write", 32'(wq_addr.size()), 32'd2);
    check_output("both_no_oe", 32'(oe_low), 32'd0);
    apply_stimulus(0, 1, 32'd1040, 32'h0);
    check_output("both_readback", rd_at_ready, 32'hA5A55A5A);

    $display("[TB] three clocks per access");
    wr3 = 1'b1;
    rd3 = 1'b1;
    lat3 = 0;
    we3 = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sram_we_n3 === 1'b0) we3++;
      if (ready3 === 1'b1) break;
      lat3++;
    end
    check_output("ac3_latency", 32'(lat3), 32'd7);
    check_output("ac3_we_cycles", 32'(we3), 32'd4);
    check_output("ac3_high_addr", 32'(sram_addr3), 32'd1);
    check_output("ac3_high_dq", 32'(sram_dq_out3), 32'h1234);
    check_output("ac3_read_data", read_data3, 32'h0);
    @(posedge clk);
    #1;
    wr3 = 1'b0;
    rd3 = 1'b0;

    $display("[TB] randomized traffic");
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0)
        a = $urandom;
      else
        a = 32'(BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3));
      apply_stimulus(op != 1, op != 0, a, $urandom);
      check_output("rand_latency", 32'(lat), 32'd5);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 500000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
